pipeline_stall_ctrl: RTL and testbench



---
 rtl/pipeline_ctrl_pkg.sv | 41 ++++
 rtl/sat_counter.sv | 22 ++
 rtl/pipeline_stall_ctrl.sv | 98 +++++++++
 tb/tb_pipeline_stall_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM states, the
// per-stage control bundle and the nop encoding loaded by bubbles and flushes.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    TRAP  = 2'd3
  } state_t;

  localparam int RUN_CNT_W = 8;

  localparam logic [5:0] NOP_OPCODE = 6'b000000;
  localparam logic [4:0] NOP_RD     = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
  } ctrl_t;

  // Pipeline frozen with a bubble into ID/EX (reset, stall and trap share it).
  function automatic ctrl_t ctrl_hold();
    return '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1};
  endfunction

  function automatic ctrl_t ctrl_idle();
    return '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};
  endfunction

  function automatic ctrl_t ctrl_flush();
    return '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1};
  endfunction

  function automatic logic is_nop(logic [5:0] opcode, logic [4:0] rd);
    return (opcode == NOP_OPCODE) && (rd == NOP_RD);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones, never wraps.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for PC, IF/ID and ID/EX with a stall watchdog.
// Optional stall/flush performance counters under STALL_PERF_CNT_EN.
module pipeline_stall_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 8,
  parameter int CNT_W     = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Stall_Req,
  input  logic             Flush_Req,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             Stall_Timeout,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  // Run count just before the edge that ends the MAX_STALL-th stall cycle.
  localparam logic [RUN_CNT_W-1:0] TRIP_CNT = RUN_CNT_W'(MAX_STALL - 1);

  state_t               state_reg;
  state_t               state_next;
  ctrl_t                ctrl;
  logic                 run_inc;
  logic                 run_clr;
  logic [RUN_CNT_W-1:0] run_cnt;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ctrl       = ctrl_hold();
    run_inc    = 1'b0;
    run_clr    = 1'b0;
    if (state_reg == TRAP) begin
      state_next = TRAP;
    end else if (Flush_Req) begin
      ctrl       = ctrl_flush();
      state_next = FLUSH;
      run_clr    = 1'b1;
    end else if (Stall_Req) begin
      ctrl       = ctrl_hold();
      run_inc    = 1'b1;
      state_next = (run_cnt >= TRIP_CNT) ? TRAP : STALL;
    end else begin
      ctrl       = ctrl_idle();
      state_next = RUN;
      run_clr    = 1'b1;
    end
  end

  sat_counter #(.WIDTH(RUN_CNT_W)) u_run_cnt (
    .clk   (Clock),
    .rst_n (Reset),
    .inc   (run_inc),
    .clr   (run_clr),
    .count (run_cnt)
  );

  // Reset quiets the pipeline combinationally, without waiting for an edge.
  assign PC_Write      = Reset & ctrl.pc_write;
  assign IFID_Write    = Reset & ctrl.ifid_write;
  assign IFID_Flush    = Reset & ctrl.ifid_flush;
  assign IDEX_Bubble   = ~Reset | ctrl.idex_bubble;
  assign Stall_Timeout = (state_reg == TRAP);

`ifdef STALL_PERF_CNT_EN
  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (Clock),
    .rst_n (Reset),
    .inc   (~PC_Write),
    .clr   (1'b0),
    .count (Stall_Count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (Clock),
    .rst_n (Reset),
    .inc   (IFID_Flush),
    .clr   (1'b0),
    .count (Flush_Count)
  );
`else
  assign Stall_Count = '0;
  assign Flush_Count = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (MAX_STALL=4, CNT_W=4); counter
// expectations follow STALL_PERF_CNT_EN.
module tb_pipeline_stall_ctrl;

  localparam int MAX_STALL = 4;
  localparam int CNT_W     = 4;
`ifdef STALL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             Clock = 1'b0;
  logic             Reset = 1'b0;
  logic             Stall_Req = 1'b0;
  logic             Flush_Req = 1'b0;
  logic             PC_Write;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEX_Bubble;
  logic             Stall_Timeout;
  logic [CNT_W-1:0] Stall_Count;
  logic [CNT_W-1:0] Flush_Count;

  int checks = 0;
  int errors = 0;

  pipeline_stall_ctrl #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Stall_Req     (Stall_Req),
    .Flush_Req     (Flush_Req),
    .PC_Write      (PC_Write),
    .IFID_Write    (IFID_Write),
    .IFID_Flush    (IFID_Flush),
    .IDEX_Bubble   (IDEX_Bubble),
    .Stall_Timeout (Stall_Timeout),
    .Stall_Count   (Stall_Count),
    .Flush_Count   (Flush_Count)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Drive requests away from the rising edge, then sample shortly after.
  task automatic step(input logic s, input logic f);
    @(negedge Clock);
    Stall_Req = s;
    Flush_Req = f;
    #1;
  endtask

  task automatic check_ctrl(input string tag, input logic pc, input logic ifw,
                            input logic fl, input logic bub);
    check({tag, ".pc_write"},    PC_Write,    pc);
    check({tag, ".ifid_write"},  IFID_Write,  ifw);
    check({tag, ".ifid_flush"},  IFID_Flush,  fl);
    check({tag, ".idex_bubble"}, IDEX_Bubble, bub);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset     = 1'b0;
    Stall_Req = 1'b0;
    Flush_Req = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  initial begin
    // Reset held for 3 cycles with no requests.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      check_ctrl("reset", 1'b0, 1'b0, 1'b0, 1'b1);
      check("reset.timeout", Stall_Timeout, 1'b0);
      check("reset.stall_cnt", 32'(Stall_Count), 32'd0);
    end
    @(negedge Clock);
    Reset = 1'b1;
    step(1'b0, 1'b0);
    check_ctrl("idle_after_reset", 1'b1, 1'b1, 1'b0, 1'b0);

    // Two-cycle stall, then release.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0);
      check_ctrl("stall2", 1'b0, 1'b0, 1'b0, 1'b1);
    end
    step(1'b0, 1'b0);
    check_ctrl("stall2_release", 1'b1, 1'b1, 1'b0, 1'b0);
    check("stall2.timeout", Stall_Timeout, 1'b0);
    // Run counter must have cleared: 3 more stalls stay below the trip point.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("run_cnt_cleared.timeout", Stall_Timeout, 1'b0);
    check_ctrl("run_cnt_cleared", 1'b1, 1'b1, 1'b0, 1'b0);

    // Stall and flush together: flush wins.
    step(1'b1, 1'b1);
    check_ctrl("stall_and_flush", 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0);
    check_ctrl("after_flush_idle", 1'b1, 1'b1, 1'b0, 1'b0);

    // Back-to-back flushes.
    step(1'b0, 1'b1);
    check_ctrl("flush_b2b_1", 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1);
    check_ctrl("flush_b2b_2", 1'b1, 1'b1, 1'b1, 1'b1);

    // Flush clears the stall run: 3 + 3 stalls split by a flush never trip.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("flush_clears_run.timeout", Stall_Timeout, 1'b0);

    // Perf counters: 3 stalls and 2 flushes from a clean reset.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("perf.stall_cnt", 32'(Stall_Count), PERF ? 32'd3 : 32'd0);
    check("perf.flush_cnt", 32'(Flush_Count), PERF ? 32'd2 : 32'd0);

    // Watchdog: stall held 6 cycles trips after the 4th edge.
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b0);
      check("wdog.pc_write", PC_Write, 1'b0);
      check($sformatf("wdog.timeout_cyc%0d", i), Stall_Timeout, (i >= 5) ? 1'b1 : 1'b0);
    end
    // Trapped: requests ignored; 6 + 14 frozen edges saturate a 4-bit count.
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'(i % 2));
      check_ctrl("trap", 1'b0, 1'b0, 1'b0, 1'b1);
      check("trap.timeout", Stall_Timeout, 1'b1);
    end
    step(1'b0, 1'b0);
    check("trap.stall_cnt_sat", 32'(Stall_Count), PERF ? 32'd15 : 32'd0);
    check("trap.flush_cnt", 32'(Flush_Count), 32'd0);

    // Asynchronous reset in TRAP, mid-cycle.
    #2;
    Reset = 1'b0;
    #1;
    check("async_trap.timeout", Stall_Timeout, 1'b0);
    check_ctrl("async_trap", 1'b0, 1'b0, 1'b0, 1'b1);
    check("async_trap.stall_cnt", 32'(Stall_Count), 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    step(1'b0, 1'b0);
    check_ctrl("after_trap_reset", 1'b1, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in STALL clears state and run counter.
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0);
    #2;
    Reset = 1'b0;
    #1;
    check_ctrl("async_stall", 1'b0, 1'b0, 1'b0, 1'b1);
    check("async_stall.stall_cnt", 32'(Stall_Count), 32'd0);
    Stall_Req = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    step(1'b0, 1'b0);
    check_ctrl("after_stall_reset", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("async_stall.run_cleared", Stall_Timeout, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: simulation did not complete within bound");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
